// File: rtl/noc_virtual_channel_if.sv
// noc_virtual_channel_if: flit in/out, allocation/credit handshake and route request bundle of one VC buffer
interface noc_virtual_channel_if #(
    parameter int FLIT_W  = 10,
    parameter int OUT_N_W = 3
);
    logic [FLIT_W-1:0]  data_i;
    logic               wr_en_i;
    logic               chan_alloc_i;
    logic               chan_rdy_i;
    logic [FLIT_W-1:0]  data_o;
    logic               data_vld_o;
    logic [FLIT_W-1:0]  header_o;
    logic [OUT_N_W-1:0] route_res_o;
    logic               route_res_vld_o;
    logic               rdy_o;
    modport slave (
        input  data_i, wr_en_i, chan_alloc_i, chan_rdy_i,
        output data_o, data_vld_o, header_o, route_res_o, route_res_vld_o, rdy_o
    );
    modport master (
        output data_i, wr_en_i, chan_alloc_i, chan_rdy_i,
        input  data_o, data_vld_o, header_o, route_res_o, route_res_vld_o, rdy_o
    );
endinterface

// File: rtl/noc_virtual_channel.sv
// noc_virtual_channel: 2D-mesh router VC input buffer (flit FIFO, XY route of head packet, credit-gated forwarding)
// Ports: clk_i, rst_ni (async active-low); bus (slave): data_i/wr_en_i in, chan_alloc_i/chan_rdy_i handshake,
// data_o/data_vld_o out, header_o/route_res_o/route_res_vld_o route request, rdy_o = FIFO not full.
// Option: define VC_HOP_INC_EN to increment the header hop count (mod 2**HOP_CNT_W) on header_o and the forwarded header.
module noc_virtual_channel #(
    parameter int         VC_DEPTH_W  = 2,
    parameter int         FLIT_DATA_W = 8,
    parameter int         FLIT_ID_W   = 2,
    parameter logic [3:0] COL_CORD    = 4'd1,
    parameter logic [3:0] ROW_CORD    = 4'd1,
    parameter int         COL_ADDR_W  = 2,
    parameter int         ROW_ADDR_W  = 2,
    parameter int         OUT_N_W     = 3,
    parameter int         HOP_CNT_W   = 4,
    parameter int         FLIT_W      = FLIT_DATA_W + FLIT_ID_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    noc_virtual_channel_if.slave  bus
);
    localparam int DEPTH   = 1 << VC_DEPTH_W;
    localparam int CW      = COL_ADDR_W > 4 ? COL_ADDR_W : 4;
    localparam int RW      = ROW_ADDR_W > 4 ? ROW_ADDR_W : 4;
    localparam int HOP_LSB = COL_ADDR_W + ROW_ADDR_W;
    localparam logic [FLIT_ID_W-1:0] ID_HDR  = FLIT_ID_W'(1);
    localparam logic [FLIT_ID_W-1:0] ID_TAIL = FLIT_ID_W'(3);
    localparam logic [OUT_N_W-1:0] LOCAL = OUT_N_W'(0);
    localparam logic [OUT_N_W-1:0] NORTH = OUT_N_W'(1);
    localparam logic [OUT_N_W-1:0] EAST  = OUT_N_W'(2);
    localparam logic [OUT_N_W-1:0] SOUTH = OUT_N_W'(3);
    localparam logic [OUT_N_W-1:0] WEST  = OUT_N_W'(4);

    typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_e;

    state_e                state_q, state_d;
    logic [FLIT_W-1:0]     mem_q [DEPTH];
    logic [VC_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [VC_DEPTH_W:0]   cnt_q;
    logic [FLIT_W-1:0]     hdr_q, head, head_fix;
    logic [FLIT_ID_W-1:0]  head_id;
    logic [OUT_N_W-1:0]    route_q, route_d;
    logic [CW-1:0]         dcol;
    logic [RW-1:0]         drow;
    logic                  full, empty, push, pop, latch, fwd;

    assign full    = cnt_q == (VC_DEPTH_W+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign push    = bus.wr_en_i && !full;
    assign head    = mem_q[rd_ptr_q];
    assign head_id = head[FLIT_W-1 -: FLIT_ID_W];
    assign dcol    = CW'(head[COL_ADDR_W-1:0]);
    assign drow    = RW'(head[COL_ADDR_W +: ROW_ADDR_W]);
    assign route_d = dcol > CW'(COL_CORD) ? EAST  :
                     dcol < CW'(COL_CORD) ? WEST  :
                     drow > RW'(ROW_CORD) ? SOUTH :
                     drow < RW'(ROW_CORD) ? NORTH : LOCAL;

    always_comb begin
        head_fix = head;
`ifdef VC_HOP_INC_EN
        head_fix[HOP_LSB +: HOP_CNT_W] = head[HOP_LSB +: HOP_CNT_W] + HOP_CNT_W'(1);
`endif
    end

    // IDLE drops any non-header flit at the head so a stray body/tail cannot wedge the VC.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        fwd     = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                latch   = !empty && head_id == ID_HDR;
                pop     = !empty && head_id != ID_HDR;
                state_d = latch ? ROUTE : IDLE;
            end
            ROUTE:  state_d = bus.chan_alloc_i ? ACTIVE : ROUTE;
            ACTIVE: begin
                fwd     = !empty && bus.chan_rdy_i;
                pop     = fwd;
                state_d = fwd && head_id == ID_TAIL ? IDLE : ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            hdr_q    <= '0;
            route_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + VC_DEPTH_W'(push);
            rd_ptr_q <= rd_ptr_q + VC_DEPTH_W'(pop);
            cnt_q    <= cnt_q + (VC_DEPTH_W+1)'(push) - (VC_DEPTH_W+1)'(pop);
            if (latch) begin
                hdr_q   <= head_fix;
                route_q <= route_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_i;
    end

    assign bus.data_o          = head_id == ID_HDR ? head_fix : head;
    assign bus.data_vld_o      = fwd;
    assign bus.header_o        = hdr_q;
    assign bus.route_res_o     = route_q;
    assign bus.route_res_vld_o = state_q == ROUTE;
    assign bus.rdy_o           = !full;
endmodule

// File: tb/tb_noc_virtual_channel.sv
// tb_noc_virtual_channel: directed self-checking bench for the VC buffer (routing table, packet flow, backpressure, credit stall, reset)
module tb_noc_virtual_channel;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    noc_virtual_channel_if #(.FLIT_W(10), .OUT_N_W(3)) vc();
    noc_virtual_channel dut (.clk_i(clk), .rst_ni(rst_n), .bus(vc.slave));

    typedef struct {
        logic [9:0] hdr;
        logic [2:0] route;
        string      name;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [9:0] exp_hdr(input logic [9:0] h);
        logic [9:0] r;
        r = h;
`ifdef VC_HOP_INC_EN
        r[7:4] = h[7:4] + 4'd1;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] d);
        vc.data_i  = d;
        vc.wr_en_i = 1'b1;
        tick();
        vc.wr_en_i = 1'b0;
    endtask

    task automatic do_reset();
        vc.wr_en_i      = 1'b0;
        vc.chan_alloc_i = 1'b0;
        vc.chan_rdy_i   = 1'b0;
        vc.data_i       = '0;
        rst_n           = 1'b0;
        tick();
        tick();
        chk("rst_route_vld", 32'(vc.route_res_vld_o), 0);
        chk("rst_data_vld", 32'(vc.data_vld_o), 0);
        chk("rst_rdy", 32'(vc.rdy_o), 1);
        chk("rst_header", 32'(vc.header_o), 0);
        chk("rst_route", 32'(vc.route_res_o), 0);
        rst_n = 1'b1;
    endtask

    logic [9:0] h, b, t, b2, x;

    initial begin
        vecs[0] = '{10'b01_0000_01_11, 3'd2, "east"};
        vecs[1] = '{10'b01_0000_01_00, 3'd4, "west"};
        vecs[2] = '{10'b01_0000_00_01, 3'd1, "north"};
        vecs[3] = '{10'b01_0000_11_01, 3'd3, "south"};
        vecs[4] = '{10'b01_0000_01_01, 3'd0, "local"};
        vecs[5] = '{10'b01_0011_00_10, 3'd2, "col_first"};
        vecs[6] = '{10'b01_1111_01_01, 3'd0, "hop_wrap"};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            wr(vecs[i].hdr);
            chk({vecs[i].name, "_lat"}, 32'(vc.route_res_vld_o), 0);
            tick();
            chk({vecs[i].name, "_vld"}, 32'(vc.route_res_vld_o), 1);
            chk({vecs[i].name, "_route"}, 32'(vc.route_res_o), 32'(vecs[i].route));
            chk({vecs[i].name, "_hdr"}, 32'(vc.header_o), 32'(exp_hdr(vecs[i].hdr)));
        end

        // full packet with a 5-cycle allocation wait
        h = 10'b01_1111_01_11;
        b = 10'b10_10101010;
        t = 10'b11_01010101;
        do_reset();
        wr(h);
        wr(b);
        wr(t);
        for (int i = 0; i < 5; i++) begin
            chk("wait_vld", 32'(vc.route_res_vld_o), 1);
            chk("wait_route", 32'(vc.route_res_o), 2);
            chk("wait_hdr", 32'(vc.header_o), 32'(exp_hdr(h)));
            chk("wait_data_vld", 32'(vc.data_vld_o), 0);
            tick();
        end
        vc.chan_alloc_i = 1'b1;
        vc.chan_rdy_i   = 1'b1;
        tick();
        vc.chan_alloc_i = 1'b0;
        chk("pkt_vld0", 32'(vc.data_vld_o), 1);
        chk("pkt_hdr", 32'(vc.data_o), 32'(exp_hdr(h)));
        chk("pkt_route_vld", 32'(vc.route_res_vld_o), 0);
        tick();
        chk("pkt_vld1", 32'(vc.data_vld_o), 1);
        chk("pkt_body", 32'(vc.data_o), 32'(b));
        tick();
        chk("pkt_vld2", 32'(vc.data_vld_o), 1);
        chk("pkt_tail", 32'(vc.data_o), 32'(t));
        tick();
        chk("pkt_end_vld", 32'(vc.data_vld_o), 0);
        chk("pkt_end_route_vld", 32'(vc.route_res_vld_o), 0);
        tick();
        chk("pkt_idle_route_vld", 32'(vc.route_res_vld_o), 0);

        // backpressure, dropped 5th write, credit stalls
        h  = 10'b01_0000_00_01;
        b  = 10'b10_00110011;
        b2 = 10'b00_11001100;
        t  = 10'b11_00001111;
        x  = 10'b11_11111111;
        do_reset();
        wr(h);
        chk("bp_rdy1", 32'(vc.rdy_o), 1);
        wr(b);
        chk("bp_rdy2", 32'(vc.rdy_o), 1);
        wr(b2);
        chk("bp_rdy3", 32'(vc.rdy_o), 1);
        wr(t);
        chk("bp_rdy4", 32'(vc.rdy_o), 0);
        wr(x);
        chk("bp_rdy5", 32'(vc.rdy_o), 0);
        vc.chan_alloc_i = 1'b1;
        tick();
        vc.chan_alloc_i = 1'b0;
        chk("stall_vld_a", 32'(vc.data_vld_o), 0);
        tick();
        chk("stall_vld_b", 32'(vc.data_vld_o), 0);
        chk("stall_rdy", 32'(vc.rdy_o), 0);
        vc.chan_rdy_i = 1'b1;
        #1;
        chk("res_vld_h", 32'(vc.data_vld_o), 1);
        chk("res_hdr", 32'(vc.data_o), 32'(exp_hdr(h)));
        tick();
        chk("pop_rdy", 32'(vc.rdy_o), 1);
        vc.chan_rdy_i = 1'b0;
        #1;
        chk("mid_stall_a", 32'(vc.data_vld_o), 0);
        tick();
        chk("mid_stall_b", 32'(vc.data_vld_o), 0);
        vc.chan_rdy_i = 1'b1;
        #1;
        chk("res_vld_b", 32'(vc.data_vld_o), 1);
        chk("res_body", 32'(vc.data_o), 32'(b));
        tick();
        chk("res_vld_b2", 32'(vc.data_vld_o), 1);
        chk("res_body2", 32'(vc.data_o), 32'(b2));
        tick();
        chk("res_vld_t", 32'(vc.data_vld_o), 1);
        chk("res_tail", 32'(vc.data_o), 32'(t));
        tick();
        chk("drop_vld", 32'(vc.data_vld_o), 0);
        chk("drop_route_vld", 32'(vc.route_res_vld_o), 0);
        chk("drop_rdy", 32'(vc.rdy_o), 1);

        // async reset mid-packet, then stray body flit discarded ahead of a header
        h = 10'b01_0000_11_11;
        do_reset();
        vc.chan_alloc_i = 1'b1;
        vc.chan_rdy_i   = 1'b1;
        wr(h);
        wr(10'b10_11110000);
        tick();
        chk("mid_fwd_hdr", 32'(vc.data_vld_o), 1);
        tick();
        chk("mid_fwd_body", 32'(vc.data_vld_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_route_vld", 32'(vc.route_res_vld_o), 0);
        chk("arst_data_vld", 32'(vc.data_vld_o), 0);
        chk("arst_rdy", 32'(vc.rdy_o), 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_data_vld", 32'(vc.data_vld_o), 0);
        chk("post_rst_route_vld", 32'(vc.route_res_vld_o), 0);
        vc.chan_alloc_i = 1'b0;
        wr(10'b10_00000011);
        wr(h);
        tick();
        chk("discard_vld", 32'(vc.route_res_vld_o), 1);
        chk("discard_hdr", 32'(vc.header_o), 32'(exp_hdr(h)));
        chk("discard_route", 32'(vc.route_res_o), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
